// File: rtl/data_receiver_stallable.sv
// Return-data receiver for a fixed-latency functional unit: tracks accepted requests,
// bypasses or buffers results in order, and issues credits so the buffer never overflows.
module data_receiver_stallable #(
  parameter int latency     = 1,
  parameter int data_width  = 32,
  parameter int fifo_depth  = latency + 1,
  parameter int count_width = $clog2(fifo_depth + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   op_start,
  output logic                   op_ready,
  input  logic                   user_enable,
  input  logic                   user_stall,
  input  logic [data_width-1:0]  data_in,
  output logic [data_width-1:0]  data_out,
  output logic                   data_out_valid,
  output logic [count_width-1:0] occupancy,
  output logic [count_width-1:0] outstanding,
  output logic                   overflow_err,
  output logic                   underflow_err
);

  localparam int ptr_width = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam logic [count_width-1:0] depth_c  = count_width'(fifo_depth);
  localparam logic [ptr_width-1:0]   last_ptr = ptr_width'(fifo_depth - 1);

  logic [latency-1:0]    valid_sr;
  logic [ptr_width-1:0]  rd_ptr;
  logic [ptr_width-1:0]  wr_ptr;
  logic [count_width-1:0] count;
  logic [data_width-1:0] mem [fifo_depth];

  logic accept;
  logic take;
  logic in_valid;
  logic empty;
  logic full;
  logic wr;
  logic wr_en;
  logic rd;
  logic consumed;

  assign accept   = op_start & op_ready;
  assign take     = user_enable & ~user_stall;
  assign in_valid = valid_sr[latency-1];
  assign empty    = (count == '0);
  assign full     = (count == depth_c);

  // A result meeting a take on an empty buffer goes straight through and is never stored.
  assign wr       = in_valid & (~empty | ~take);
  assign wr_en    = wr & ~full;
  assign rd       = take & ~empty;
  assign consumed = take & data_out_valid;

  assign data_out       = empty ? data_in : mem[rd_ptr];
  assign data_out_valid = ~empty | in_valid;
  assign occupancy      = count;

  // Credit depends only on registered state, so a take frees a slot one cycle later.
  assign op_ready = (outstanding < depth_c);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_sr      <= '0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      outstanding   <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      valid_sr <= (valid_sr << 1) | latency'(accept);
      if (wr_en) wr_ptr <= (wr_ptr == last_ptr) ? '0 : wr_ptr + 1'b1;
      if (rd)    rd_ptr <= (rd_ptr == last_ptr) ? '0 : rd_ptr + 1'b1;
      count         <= count + count_width'(wr_en) - count_width'(rd);
      outstanding   <= outstanding + count_width'(accept) - count_width'(consumed);
      overflow_err  <= overflow_err | (wr & full);
      underflow_err <= underflow_err | (take & ~data_out_valid);
    end
  end

  // NOTE: the storage array has no reset; count and pointers alone decide which
  // entries are meaningful, so clearing the data would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= data_in;
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!reset && wr && full && !overflow_err) begin
      $error("data_receiver_stallable: write while buffer full, result dropped");
      $finish;
    end
  end
`endif

endmodule

// File: tb/tb_data_receiver_stallable.sv
// Self-checking bench: two receiver instances (depth 4 and depth 3, latency 3) driven by
// fixed-latency FU models, with per-instance scoreboards checking result order.
module tb_data_receiver_stallable;

  localparam int lat  = 3;
  localparam int dw   = 32;
  localparam int cw_a = $clog2(4 + 1);
  localparam int cw_b = $clog2(3 + 1);

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- instance A: depth 4 ----------------
  logic a_op_start = 1'b0, a_user_enable = 1'b0, a_user_stall = 1'b0;
  logic [dw-1:0] a_req = '0;
  logic a_op_ready, a_data_out_valid, a_overflow_err, a_underflow_err;
  logic [dw-1:0] a_data_in, a_data_out;
  logic [cw_a-1:0] a_occupancy, a_outstanding;

  data_receiver_stallable #(.latency(lat), .data_width(dw), .fifo_depth(4)) dut_a (
    .clk(clk), .reset(reset), .op_start(a_op_start), .op_ready(a_op_ready),
    .user_enable(a_user_enable), .user_stall(a_user_stall), .data_in(a_data_in),
    .data_out(a_data_out), .data_out_valid(a_data_out_valid), .occupancy(a_occupancy),
    .outstanding(a_outstanding), .overflow_err(a_overflow_err), .underflow_err(a_underflow_err)
  );

  // ---------------- instance B: depth 3 ----------------
  logic b_op_start = 1'b0, b_user_enable = 1'b0, b_user_stall = 1'b0;
  logic [dw-1:0] b_req = '0;
  logic b_op_ready, b_data_out_valid, b_overflow_err, b_underflow_err;
  logic [dw-1:0] b_data_in, b_data_out;
  logic [cw_b-1:0] b_occupancy, b_outstanding;

  data_receiver_stallable #(.latency(lat), .data_width(dw), .fifo_depth(3)) dut_b (
    .clk(clk), .reset(reset), .op_start(b_op_start), .op_ready(b_op_ready),
    .user_enable(b_user_enable), .user_stall(b_user_stall), .data_in(b_data_in),
    .data_out(b_data_out), .data_out_valid(b_data_out_valid), .occupancy(b_occupancy),
    .outstanding(b_outstanding), .overflow_err(b_overflow_err), .underflow_err(b_underflow_err)
  );

  // Fixed-latency FU models; deliberately not reset so late returns still appear.
  logic [lat-1:0] a_fu_v = '0;
  logic [lat-1:0] b_fu_v = '0;
  logic [dw-1:0]  a_fu_d [lat];
  logic [dw-1:0]  b_fu_d [lat];

  always @(posedge clk) begin
    a_fu_v <= {a_fu_v[lat-2:0], a_op_start & a_op_ready};
    b_fu_v <= {b_fu_v[lat-2:0], b_op_start & b_op_ready};
    a_fu_d[0] <= a_req;
    b_fu_d[0] <= b_req;
    for (int i = 1; i < lat; i++) begin
      a_fu_d[i] <= a_fu_d[i-1];
      b_fu_d[i] <= b_fu_d[i-1];
    end
  end

  assign a_data_in = a_fu_v[lat-1] ? a_fu_d[lat-1] : 32'hDEAD_BEEF;
  assign b_data_in = b_fu_v[lat-1] ? b_fu_d[lat-1] : 32'hDEAD_BEEF;

  // Scoreboards: push the request payload on issue, pop on each consumed result.
  logic [dw-1:0] a_q [$];
  logic [dw-1:0] b_q [$];
  int b_recv = 0;

  always @(posedge clk) begin
    if (reset) begin
      a_q.delete();
      b_q.delete();
    end else begin
      if (a_op_start && a_op_ready) a_q.push_back(a_req);
      if (b_op_start && b_op_ready) b_q.push_back(b_req);
    end
  end

  always @(negedge clk) begin
    if (!reset && a_user_enable && !a_user_stall && a_data_out_valid) begin
      check("a_sb_nonempty", 32'(a_q.size() != 0), 32'd1);
      if (a_q.size() != 0) check("a_order", a_data_out, a_q.pop_front());
    end
    if (!reset && b_user_enable && !b_user_stall && b_data_out_valid) begin
      check("b_sb_nonempty", 32'(b_q.size() != 0), 32'd1);
      if (b_q.size() != 0) check("b_order", b_data_out, b_q.pop_front());
      b_recv++;
    end
  end

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sent;
    adv();
    adv();
    reset = 1'b0;

    // Reset state
    settle();
    check("rst_op_ready", a_op_ready, 1);
    check("rst_valid", a_data_out_valid, 0);
    check("rst_occ", a_occupancy, 0);
    check("rst_outstanding", a_outstanding, 0);
    check("rst_ovf", a_overflow_err, 0);
    check("rst_unf", a_underflow_err, 0);
    check("rst_passthru", a_data_out, 32'hDEAD_BEEF);
    adv();

    // Bypass: accept in cycle 0, take in cycle 3
    for (int c = 0; c < 5; c++) begin
      a_op_start    = (c == 0);
      a_req         = 32'hA5;
      a_user_enable = (c == 3);
      settle();
      if (c == 1) check("t1_outstanding", a_outstanding, 1);
      if (c == 3) begin
        check("t1_data", a_data_out, 32'hA5);
        check("t1_valid", a_data_out_valid, 1);
        check("t1_occ", a_occupancy, 0);
      end
      if (c == 4) begin
        check("t1_occ_after", a_occupancy, 0);
        check("t1_outst_after", a_outstanding, 0);
        check("t1_valid_after", a_data_out_valid, 0);
      end
      adv();
    end

    // Stall buffers three results, then they drain in order
    for (int c = 0; c < 10; c++) begin
      a_op_start    = (c < 3);
      a_req         = 32'(c + 1);
      a_user_enable = (c >= 3 && c <= 8);
      a_user_stall  = (c >= 3 && c <= 5);
      settle();
      if (c == 5) begin
        check("t2_hold_head", a_data_out, 1);
        check("t2_occ_c5", a_occupancy, 2);
      end
      if (c == 6) check("t2_occ_c6", a_occupancy, 3);
      if (c == 9) begin
        check("t2_valid_end", a_data_out_valid, 0);
        check("t2_occ_end", a_occupancy, 0);
        check("t2_outst_end", a_outstanding, 0);
      end
      adv();
    end
    a_user_stall = 1'b0;

    // Credit exhaustion and return
    for (int c = 0; c < 13; c++) begin
      a_op_start    = (c <= 7);
      a_req         = 32'h30 + 32'(c);
      a_user_enable = (c >= 8);
      settle();
      if (c == 3) check("t3_ready_c3", a_op_ready, 1);
      if (c >= 4 && c <= 8) check("t3_ready_low", a_op_ready, 0);
      if (c == 7) begin
        check("t3_occ_full", a_occupancy, 4);
        check("t3_outst_full", a_outstanding, 4);
      end
      if (c == 9) begin
        check("t3_ready_back", a_op_ready, 1);
        check("t3_outst_c9", a_outstanding, 3);
        check("t3_occ_c9", a_occupancy, 3);
      end
      if (c == 12) begin
        check("t3_valid_end", a_data_out_valid, 0);
        check("t3_ovf", a_overflow_err, 0);
      end
      adv();
    end
    a_user_enable = 1'b0;

    // Reset with two results buffered and one still in the FU
    for (int c = 0; c < 8; c++) begin
      a_op_start = (c == 0 || c == 1 || c == 3);
      a_req      = (c == 3) ? 32'h53 : 32'h51 + 32'(c);
      reset      = (c == 5);
      settle();
      if (c == 5) check("t5_occ_pre", a_occupancy, 2);
      if (c == 6) begin
        check("t5_valid", a_data_out_valid, 0);
        check("t5_occ", a_occupancy, 0);
        check("t5_outst", a_outstanding, 0);
        check("t5_ready", a_op_ready, 1);
        check("t5_late_passthru", a_data_out, 32'h53);
      end
      if (c == 7) begin
        check("t5_late_ignored", a_occupancy, 0);
        check("t5_valid_c7", a_data_out_valid, 0);
      end
      adv();
    end
    a_op_start = 1'b0;

    // Underflow is sticky until reset
    a_user_enable = 1'b1;
    settle();
    adv();
    a_user_enable = 1'b0;
    settle();
    check("t6_unf_set", a_underflow_err, 1);
    check("t6_occ", a_occupancy, 0);
    adv();
    adv();
    settle();
    check("t6_unf_sticky", a_underflow_err, 1);
    adv();
    reset = 1'b1;
    adv();
    reset = 1'b0;
    settle();
    check("t6_unf_cleared", a_underflow_err, 0);
    adv();

    // Depth-3 stream of ten results through a stall/take pattern
    sent = 0;
    for (int c = 0; c < 200 && b_recv < 10; c++) begin
      b_op_start    = (sent < 10);
      b_req         = 32'h100 + 32'(sent);
      b_user_enable = 1'b1;
      b_user_stall  = (c % 7) < 3;
      settle();
      if (b_op_start && b_op_ready) sent++;
      adv();
    end
    b_op_start    = 1'b0;
    b_user_enable = 1'b0;
    b_user_stall  = 1'b0;
    check("t4_recv", 32'(b_recv), 32'd10);
    check("t4_sb_empty", 32'(b_q.size()), 32'd0);
    check("t4_ovf", b_overflow_err, 0);
    check("a_sb_empty", 32'(a_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/data_receiver_stallable.md
# data_receiver_stallable

Return-data receiver for a fixed-latency functional unit (FU) or RAM port in HLS-generated datapaths, supporting consumer stalls and issue-side flow control. It tracks accepted requests through a latency shift register and delivers FU results to the user state in order. Results are bypassed combinationally when the user is ready, or buffered in an internal first-word-fall-through (FWFT) store when the user is not ready or is stalled. A credit output (`op_ready`) throttles new requests so the buffer can never overflow. This supersedes the fixed-depth receiver in pipelines that need `fsm_stall` / back-pressure.

## Interface
- `latency`, default 1: FU cycles from an accepted request to valid `data_in`; must be ≥1.
- `data_width`, default 32: width of the return data.
- `fifo_depth`, default `latency+1`: buffer entries and maximum outstanding requests; must be ≥1, need not be a power of two.
- `count_width`, default `$clog2(fifo_depth+1)`: width of the occupancy and outstanding counters.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `op_start`  in  1  request issued to the FU this cycle; it is accepted only when `op_ready`=1.
- `op_ready`  out  1  credit available, so a request may issue.
- `user_enable`  in  1  the datapath expects a result this cycle.
- `user_stall`  in  1  the datapath is stalled; while high, no result is consumed.
- `data_in`  in  `data_width`  return data from the FU.
- `data_out`  out  `data_width`  result presented to the datapath.
- `data_out_valid`  out  1  `data_out` holds a real result.
- `occupancy`  out  `count_width`  number of buffered entries.
- `outstanding`  out  `count_width`  requests accepted but not yet consumed.
- `overflow_err`  out  1  sticky: a write was attempted while the buffer was full.
- `underflow_err`  out  1  sticky: a take occurred with no valid data.

## Operation
- Derived signals:
  - `accept` = `op_start & op_ready`.
  - `take` = `user_enable & !user_stall`.
- Valid-tracking shift register, `latency` bits wide:
  - `accept` enters at bit 0 and the register shifts every cycle, independent of the stall.
  - `in_valid` = bit `latency-1`.
- Buffer: circular, `fifo_depth` entries, with read pointer, write pointer and count.
  - Pointers wrap explicitly from `fifo_depth-1` to 0.
  - `empty` = (count == 0).
- Write rule: `wr` = `in_valid & (!empty | !take)`. When `in_valid` and `take` coincide with an empty buffer, the data bypasses the buffer and is not written.
- Read rule: `rd` = `take & !empty`, which pops the head.
- Output path:
  - `data_out` = `empty ? data_in : head`.
  - `data_out_valid` = `!empty | in_valid`.
- Counters:
  - Count changes by +`wr` −`rd`; a simultaneous write and read leaves it unchanged.
  - `outstanding` changes by +`accept` −(`take & data_out_valid`).
- Credit: `op_ready` = (`outstanding` < `fifo_depth`), computed from registered state only, with no same-cycle return of credit on a take. Because buffered entries never exceed `outstanding`, the buffer cannot overflow under legal use.
- Errors:
  - `overflow_err` sets on `wr` while count == `fifo_depth`. The write is dropped.
  - `underflow_err` sets on `take & !data_out_valid`. Nothing is popped.
  - Both errors clear only on `reset`.
  - Simulation-only check (excluded from synthesis): print an error and `$finish` when `overflow_err` sets.
- Ordering: results are always delivered in request order.

## Timing
- Reset values: `op_ready`=1, `data_out_valid`=0, `occupancy`=0, `outstanding`=0, both errors 0, shift register all 0, pointers 0. `data_out` follows `data_in` while empty.
- An `accept` registered at the edge ending cycle t gives `in_valid`=1 in cycle t+`latency`.
- Bypass path, zero added latency: `take` in cycle t+`latency` with an empty buffer consumes `data_in` directly.
- Buffered path: an entry written at the end of cycle t+`latency` appears on `data_out` in cycle t+`latency`+1 and is held until taken.
- `op_ready` falls in the cycle after `outstanding` reaches `fifo_depth`, and rises in the cycle after a take.
- Reset mid-operation: all in-flight and buffered results are discarded. FU returns arriving after reset are ignored, because the shift register has been cleared.
- Stall: `user_stall`=1 blocks `take`, so returning data is buffered and `data_out` holds the head.

## Test plan
- latency=3, depth=4: `accept` at cycle 0 with `data_in`=0xA5 at cycle 3 and `user_enable`=1 in cycle 3 → `data_out`=0xA5 in cycle 3, `occupancy` stays 0, `outstanding` returns to 0.
- latency=3: accepts at cycles 0,1,2 with data 1,2,3, `user_stall`=1 during cycles 3–5, take in cycles 6–8 → `occupancy`=3 in cycle 6, outputs in order 1,2,3, then `data_out_valid`=0.
- depth=4: hold `op_start`=1 with no take → exactly 4 accepts, `op_ready`=0 from cycle 4; one take → `op_ready`=1 the next cycle, `overflow_err` stays 0.
- depth=3 (non-power-of-2): stream 10 results through a stall/take pattern → correct order across pointer wraparound.
- Reset asserted while 2 results are buffered and 1 is in flight → all outputs at reset values the next cycle; the late FU return is not captured.
- `user_enable`=1 with nothing valid → `underflow_err`=1 and stays set until `reset`; `occupancy` unchanged.
